link_act_multi: RTL and testbench
=================================

// Module: link_act_multi
// PURPOSE
//  Parametrised N-channel link/activity LED controller. It succeeds the
//  single-channel link_act driver on board tops.
//  Each channel takes a LINK level (e.g. Aurora CH_UP) and one-cycle ACT
//  pulses (e.g. port VALID & ~BP). It stretches activity into visible blinks
//  and keeps saturating per-channel activity counts.
//  A registered LED output shows one selected channel or an aggregate, and
//  LED_ALL_UP replaces ad-hoc &GT_UP reductions in tops.
// PARAMETERS
//  NCH            4        number of channels (1..16)
//  TICK_CYC       250000   CLK cycles per tick (1 ms at 250 MHz); >=2
//  STRETCH_TICKS  50       ticks an ACT pulse keeps a channel in ACTIVE
//  BLINK_TICKS    25       ticks per blink half-period
//  CNT_W          16       width of each activity counter
// PORTS
//  CLK         in   1            system clock (router/PCIe clock)
//  RST_N       in   1            async active-low reset
//  LINK        in   NCH          per-channel link-up level
//  ACT         in   NCH          per-channel activity pulse, 1 cycle = 1 event
//  MODE        in   2            0=selected ch, 1=any ch, 2=all-up steady, 3=off
//  SEL         in   clog2(NCH)   channel shown in MODE 0 (min width 1)
//  CLR         in   1            sync clear of all activity counters
//  LED         out  1            registered LED drive, 1=on
//  LED_ALL_UP  out  1            registered &LINK
//  ACT_CNT     out  NCH*CNT_W    counters, ch i at [i*CNT_W +: CNT_W]
// BEHAVIOUR
//  - Reset (async on RST_N low, sync release): all channels DOWN; prescaler,
//    stretch counters, blink phase and ACT_CNT are 0; LED=0, LED_ALL_UP=0.
//  - Prescaler: counts 0..TICK_CYC-1; TICK is high for 1 cycle at wrap.
//  - Blink phase: toggles every BLINK_TICKS ticks; free-running, shared by all
//    channels; phase=0 means lamp off.
//  - Per-channel FSM, states DOWN / IDLE / ACTIVE, evaluated every cycle:
//    DOWN->IDLE when LINK=1 and ACT=0. DOWN->ACTIVE when LINK=1 and ACT=1.
//    IDLE->ACTIVE on ACT. Any state->DOWN when LINK=0; this takes priority
//    and zeroes stretch.
//    Every ACT in IDLE or ACTIVE reloads stretch=STRETCH_TICKS.
//    In ACTIVE, each TICK decrements stretch. ACTIVE->IDLE when stretch=1 and
//    TICK and no ACT in that cycle. ACT on the same cycle as the expiring TICK
//    reloads and stays ACTIVE.
//    ACT while LINK=0 is ignored (no state change, no count).
//  - Channel lamp: DOWN=0, IDLE=1, ACTIVE=blink phase.
//  - LED (registered, latency 2 cycles from LINK/ACT edge to LED change):
//    MODE0 = lamp[SEL], and 0 if SEL>=NCH.
//    MODE1 = phase if any ch ACTIVE; else 1 if any ch IDLE; else 0.
//    MODE2 = &LINK. MODE3 = 0.
//    MODE/SEL changes take effect on LED in 1 cycle.
//  - LED_ALL_UP: &LINK registered, 1-cycle latency.
//  - ACT_CNT[i]: +1 per ACT[i] with LINK[i]=1. Saturates at 2^CNT_W-1 and
//    never wraps. CLR wins over a simultaneous ACT (result 0). Counts persist
//    across link drops.
//  - Assertion of RST_N mid-blink or mid-stretch returns everything to reset
//    state immediately; no partial stretch survives.
// STRUCTURE
//  - Package link_act_pkg: chan_state_t {ST_DOWN, ST_IDLE, ST_ACTIVE};
//    MODE_SEL=0, MODE_ANY=1, MODE_ALLUP=2, MODE_OFF=3.
//  - Sub-module link_act_ch: one channel's FSM, stretch counter and saturating
//    counter; inputs TICK and phase; outputs lamp, active, idle and count.
//    Generated NCH times.
//  - Top: prescaler, blink phase, output mux/registers.
// TESTING (TICK_CYC=4, STRETCH_TICKS=3, BLINK_TICKS=1, NCH=4, CNT_W=4)
//  1 Reset release, LINK=0, MODE0 SEL0 -> LED=0, LED_ALL_UP=0, ACT_CNT=0
//    for 100 cycles.
//  2 LINK[0]=1, no ACT -> LED=1 two cycles later. Then one ACT[0] -> LED
//    follows phase, toggling every 4 cycles. LED returns to steady 1 at the
//    3rd TICK after the ACT.
//  3 ACT[1] pulsed every 10 cycles with LINK[1]=1, MODE1 -> ch1 stays ACTIVE
//    and never reaches IDLE. LINK[1]=0 mid-blink -> ch1 DOWN next cycle;
//    LED=0 if all others are down.
//  4 20 ACT[2] pulses, LINK[2]=1 -> ACT_CNT[2] saturates at 15.
//    CLR with a simultaneous ACT -> 0. ACT with LINK[2]=0 -> stays 0.
//  5 LINK=4'b1111 -> LED_ALL_UP=1 after 1 cycle. MODE2 -> LED=1.
//    MODE0 with SEL beyond NCH (NCH=3 build, SEL=3) -> LED=0. MODE3 -> LED=0.
//  6 RST_N low during ACTIVE with stretch=2 -> LED=0 and ACT_CNT=0
//    asynchronously. After release with LINK held 1 -> IDLE, LED=1.

Source files
------------

// File: rtl/link_act_pkg.sv
// Shared types and helpers for the multi-channel link/activity LED controller.
package link_act_pkg;

   typedef enum logic [1:0] {
      ST_DOWN   = 2'd0,
      ST_IDLE   = 2'd1,
      ST_ACTIVE = 2'd2
   } chan_state_t;

   localparam logic [1:0] MODE_SEL   = 2'd0;
   localparam logic [1:0] MODE_ANY   = 2'd1;
   localparam logic [1:0] MODE_ALLUP = 2'd2;
   localparam logic [1:0] MODE_OFF   = 2'd3;

   // Bits needed to index/hold n distinct values, never less than 1.
   function automatic int unsigned cw(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/link_act_ch.sv
// One link/activity channel: DOWN/IDLE/ACTIVE state, tick-based activity
// stretch and a saturating activity counter.
module link_act_ch
   import link_act_pkg::*;
#(
   parameter int unsigned STRETCH_TICKS = 50,
   parameter int unsigned CNT_W         = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             link_i,
   input  logic             act_i,
   input  logic             tick_i,
   input  logic             phase_i,
   input  logic             clr_i,
   output logic             lamp_o,
   output logic             active_o,
   output logic             idle_o,
   output logic [CNT_W-1:0] cnt_o
);

   localparam int unsigned   SW         = cw(STRETCH_TICKS + 1);
   localparam logic [SW-1:0] STRETCH_LD = SW'(STRETCH_TICKS);

   chan_state_t      state_q, state_d;
   logic [SW-1:0]    stretch_q, stretch_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Link loss dominates; any qualified ACT (re)loads the stretch.
   always_comb begin
      state_d   = state_q;
      stretch_d = stretch_q;
      if (!link_i) begin
         state_d   = ST_DOWN;
         stretch_d = '0;
      end else if (act_i) begin
         state_d   = ST_ACTIVE;
         stretch_d = STRETCH_LD;
      end else begin
         case (state_q)
            ST_DOWN:   state_d = ST_IDLE;
            ST_ACTIVE: begin
               if (tick_i) begin
                  if (stretch_q == SW'(1)) begin
                     state_d   = ST_IDLE;
                     stretch_d = '0;
                  end else begin
                     stretch_d = stretch_q - SW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (act_i && link_i && (cnt_q != '1))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_DOWN;
         stretch_q <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         stretch_q <= stretch_d;
         cnt_q     <= cnt_d;
      end
   end

   assign active_o = (state_q == ST_ACTIVE);
   assign idle_o   = (state_q == ST_IDLE);
   assign lamp_o   = idle_o | (active_o & phase_i);
   assign cnt_o    = cnt_q;

endmodule

// File: rtl/link_act_multi.sv
// N-channel link/activity LED controller: shared tick prescaler and blink
// phase, per-channel FSMs, registered LED select and all-links-up output.
module link_act_multi
   import link_act_pkg::*;
#(
   parameter int unsigned NCH           = 4,
   parameter int unsigned TICK_CYC      = 250000,
   parameter int unsigned STRETCH_TICKS = 50,
   parameter int unsigned BLINK_TICKS   = 25,
   parameter int unsigned CNT_W         = 16
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic [NCH-1:0]       LINK,
   input  logic [NCH-1:0]       ACT,
   input  logic [1:0]           MODE,
   input  logic [cw(NCH)-1:0]   SEL,
   input  logic                 CLR,
   output logic                 LED,
   output logic                 LED_ALL_UP,
   output logic [NCH*CNT_W-1:0] ACT_CNT
);

   localparam int unsigned SEL_W = cw(NCH);
   localparam int unsigned PW    = cw(TICK_CYC);
   localparam int unsigned BW    = cw(BLINK_TICKS);

   logic [PW-1:0]  presc_q, presc_d;
   logic [BW-1:0]  bcnt_q, bcnt_d;
   logic           phase_q, phase_d;
   logic           led_q, led_d;
   logic           allup_q;
   logic           tick;
   logic [NCH-1:0] lamp, active, idle;

   assign tick = (presc_q == PW'(TICK_CYC - 1));

   always_comb begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      bcnt_d  = bcnt_q;
      phase_d = phase_q;
      if (tick) begin
         if (bcnt_q == BW'(BLINK_TICKS - 1)) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
         end else begin
            bcnt_d = bcnt_q + BW'(1);
         end
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      link_act_ch #(
         .STRETCH_TICKS(STRETCH_TICKS),
         .CNT_W        (CNT_W)
      ) u_ch (
         .clk_i   (CLK),
         .rst_ni  (RST_N),
         .link_i  (LINK[g]),
         .act_i   (ACT[g]),
         .tick_i  (tick),
         .phase_i (phase_q),
         .clr_i   (CLR),
         .lamp_o  (lamp[g]),
         .active_o(active[g]),
         .idle_o  (idle[g]),
         .cnt_o   (ACT_CNT[g*CNT_W +: CNT_W])
      );
   end

   // Out-of-range SEL matches no channel and leaves the LED off.
   always_comb begin
      led_d = 1'b0;
      case (MODE)
         MODE_SEL: begin
            for (int unsigned i = 0; i < NCH; i++)
               if (SEL == SEL_W'(i)) led_d = lamp[i];
         end
         MODE_ANY:   led_d = (|active) ? phase_q : (|idle);
         MODE_ALLUP: led_d = &LINK;
         MODE_OFF:   led_d = 1'b0;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         presc_q <= '0;
         bcnt_q  <= '0;
         phase_q <= 1'b0;
         led_q   <= 1'b0;
         allup_q <= 1'b0;
      end else begin
         presc_q <= presc_d;
         bcnt_q  <= bcnt_d;
         phase_q <= phase_d;
         led_q   <= led_d;
         allup_q <= &LINK;
      end
   end

   assign LED        = led_q;
   assign LED_ALL_UP = allup_q;

endmodule

// File: tb/tb_link_act_multi.sv
// Directed scoreboard bench for link_act_multi (4-channel and 3-channel builds).
module tb_link_act_multi;
   import link_act_pkg::*;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [3:0]  LINK, ACT;
   logic [1:0]  MODE, SEL;
   logic        CLR;
   logic        led4, allup4, led3, allup3;
   logic [15:0] cnt4;
   logic [11:0] cnt3;

   string        tq[$];
   logic [31:0]  eq[$];
   int unsigned  n_cmp = 0;
   int unsigned  n_err = 0;
   int unsigned  cyc = 0;
   int unsigned  n1, t3, nt, npulse;
   bit           done;

   always #5 CLK = ~CLK;

   // Edges since the last reset release; prescaler value is cyc % 4.
   always @(posedge CLK or negedge RST_N)
      if (!RST_N) cyc <= 0;
      else        cyc <= cyc + 1;

   link_act_multi #(.NCH(4), .TICK_CYC(4), .STRETCH_TICKS(3), .BLINK_TICKS(1), .CNT_W(4)) dut4 (
      .CLK(CLK), .RST_N(RST_N), .LINK(LINK), .ACT(ACT), .MODE(MODE), .SEL(SEL),
      .CLR(CLR), .LED(led4), .LED_ALL_UP(allup4), .ACT_CNT(cnt4));

   link_act_multi #(.NCH(3), .TICK_CYC(4), .STRETCH_TICKS(3), .BLINK_TICKS(1), .CNT_W(4)) dut3 (
      .CLK(CLK), .RST_N(RST_N), .LINK(LINK[2:0]), .ACT(ACT[2:0]), .MODE(MODE), .SEL(SEL),
      .CLR(CLR), .LED(led3), .LED_ALL_UP(allup3), .ACT_CNT(cnt3));

   // Blink phase after edge n: toggles on every 4th edge.
   function automatic logic ph(input int unsigned n);
      return ((n / 4) % 2) == 1;
   endfunction

   function automatic logic [31:0] cnt_of(input int unsigned ch);
      return 32'(cnt4[ch*4 +: 4]);
   endfunction

   task automatic step(input int unsigned n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic expect_v(input string tag, input logic [31:0] v);
      tq.push_back(tag);
      eq.push_back(v);
   endtask

   task automatic check_v(input logic [31:0] obs);
      string       tag;
      logic [31:0] exp_v;
      n_cmp++;
      if (eq.size() == 0) begin
         n_err++;
         $error("FAIL sb_empty: observed %0h required <none>", obs);
         return;
      end
      tag   = tq.pop_front();
      exp_v = eq.pop_front();
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp_v);
      end
   endtask

   initial begin
      RST_N = 1'b0; LINK = '0; ACT = '0; MODE = MODE_SEL; SEL = 2'd0; CLR = 1'b0;
      repeat (3) @(posedge CLK);
      #1 RST_N = 1'b1;

      // 1: quiet after reset
      for (int i = 0; i < 100; i++) begin
         expect_v("s1_reset_quiet", 32'd0);
         step(1);
         check_v({14'd0, led4, allup4, cnt4});
      end

      // 2: link up -> steady on, one ACT -> blink for three ticks
      LINK = 4'b0001;
      expect_v("s2_link_lat1", 32'd0);
      expect_v("s2_link_lat2", 32'd1);
      step(1); check_v(32'(led4));
      step(1); check_v(32'(led4));
      step(3);
      n1  = cyc;
      ACT = 4'b0001;
      expect_v("s2_act_lat1", 32'd1);
      step(1);
      ACT = '0;
      check_v(32'(led4));
      nt = 0;
      for (int unsigned e = n1 + 2; nt < 3; e++)
         if (e % 4 == 0) begin nt++; t3 = e; end
      while (cyc < t3 + 3) begin
         expect_v("s2_blink", 32'((cyc < t3) ? ph(cyc) : 1'b1));
         step(1);
         check_v(32'(led4));
      end
      expect_v("s2_cnt0", 32'd1);
      check_v(cnt_of(0));

      // 3: ch1 pulsed every 10 cycles in MODE_ANY, then link drop mid-blink
      if (cyc % 2 == 0) step(1);
      LINK = 4'b0010; ACT = 4'b0010; MODE = MODE_ANY;
      npulse = 1; done = 1'b0;
      for (int unsigned j = 1; j < 200 && !done; j++) begin
         expect_v("s3_any_blink", 32'((j == 1) ? 1'b1 : ph(cyc)));
         step(1);
         check_v(32'(led4));
         ACT = (j % 10 == 0) ? 4'b0010 : 4'b0000;
         if (j % 10 == 0) npulse++;
         if (j >= 60 && (j % 10) != 0 && ph(cyc)) done = 1'b1;
      end
      if (!done) begin
         n_cmp++; n_err++;
         $error("FAIL s3_window: observed no lamp-on window required one within 200 cycles");
      end
      LINK = '0;
      expect_v("s3_drop_lat1", 32'd1);
      expect_v("s3_drop_down", 32'd0);
      step(1); check_v(32'(led4));
      step(1); check_v(32'(led4));
      expect_v("s3_cnt1", (npulse > 15) ? 32'd15 : 32'(npulse));
      check_v(cnt_of(1));

      // 4: saturation, CLR priority, ACT ignored while link down
      MODE = MODE_SEL; SEL = 2'd2; LINK = 4'b0100;
      step(1);
      for (int unsigned i = 0; i < 20; i++) begin
         ACT = 4'b0100;
         expect_v("s4_cnt2_sat", (i + 1 < 15) ? 32'(i + 1) : 32'd15);
         step(1);
         check_v(cnt_of(2));
         ACT = '0;
         step(1);
      end
      expect_v("s4_cnt0_persist", 32'd1);
      check_v(cnt_of(0));
      CLR = 1'b1; ACT = 4'b0100;
      expect_v("s4_clr_wins", 32'd0);
      expect_v("s4_clr_all", 32'd0);
      step(1);
      CLR = 1'b0; ACT = '0;
      check_v(cnt_of(2));
      check_v(cnt_of(0));
      LINK = '0;
      step(1);
      ACT = 4'b0100;
      step(1);
      ACT = '0;
      step(1);
      expect_v("s4_act_link_down", 32'd0);
      check_v(cnt_of(2));

      // 5: all-up output and output modes
      expect_v("s5_allup_pre", 32'd0);
      check_v(32'(allup4));
      LINK = 4'b1111;
      expect_v("s5_allup4", 32'd1);
      expect_v("s5_allup3", 32'd1);
      step(1);
      check_v(32'(allup4));
      check_v(32'(allup3));
      MODE = MODE_ALLUP;
      expect_v("s5_mode_allup", 32'd1);
      step(1); check_v(32'(led4));
      MODE = MODE_ANY;
      expect_v("s5_mode_any_idle", 32'd1);
      step(1); check_v(32'(led4));
      MODE = MODE_SEL; SEL = 2'd3;
      expect_v("s5_sel3_nch4", 32'd1);
      expect_v("s5_sel3_nch3", 32'd0);
      step(1); check_v(32'(led4)); check_v(32'(led3));
      SEL = 2'd2;
      expect_v("s5_sel2_nch3", 32'd1);
      step(1); check_v(32'(led3));
      MODE = MODE_OFF;
      expect_v("s5_off4", 32'd0);
      expect_v("s5_off3", 32'd0);
      step(1); check_v(32'(led4)); check_v(32'(led3));

      // 6: async reset mid-stretch
      MODE = MODE_SEL; SEL = 2'd1; ACT = 4'b0001;
      step(1);
      ACT = '0;
      do step(1); while (cyc % 4 != 0);
      expect_v("s6_pre_led", 32'd1);
      check_v(32'(led4));
      expect_v("s6_pre_cnt0", 32'd1);
      check_v(cnt_of(0));
      RST_N = 1'b0;
      #2;
      expect_v("s6_async4", 32'd0);
      expect_v("s6_async3", 32'd0);
      check_v({14'd0, led4, allup4, cnt4});
      check_v({18'd0, led3, allup3, cnt3});
      SEL = 2'd0;
      step(1);
      RST_N = 1'b1;
      expect_v("s6_rel_led", 32'd0);
      expect_v("s6_rel_allup", 32'd1);
      step(1);
      check_v(32'(led4));
      check_v(32'(allup4));
      for (int i = 0; i < 8; i++) begin
         expect_v("s6_idle_steady", 32'd1);
         step(1);
         check_v(32'(led4));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
